fifo_golden_model: RTL
======================

Name: fifo_golden_model

Overview:
Cycle-accurate behavioural reference FIFO that sits directly upstream of the FIFO monitor. It receives the same write/read stimulus as the FIFO under test and produces the golden outputs FIFO_OUT_G, EMPTY_G and FULL_G, which the monitor compares bit-for-bit against the DUT every SYSCLK edge. It also exposes occupancy and sticky overflow/underflow indicators for bench-side checks.

Parameters:
WIDTH, 8, data width of FIFO_IN and FIFO_OUT_G
DEPTH, 16, number of storage entries; must be a power of 2, minimum 2
ADDR_W, 4, pointer width; must equal log2(DEPTH)

Ports:
SYSCLK  input  1  single clock; all state updates on rising edge
RST_N  input  1  asynchronous, active-low reset
WR_EN  input  1  write request, sampled on SYSCLK rising edge
RD_EN  input  1  read request, sampled on SYSCLK rising edge
FIFO_IN  input  WIDTH  write data, sampled together with WR_EN
FIFO_OUT_G  output  WIDTH  golden read data, registered
EMPTY_G  output  1  golden empty flag, registered
FULL_G  output  1  golden full flag, registered
COUNT_G  output  ADDR_W+1  number of occupied entries, 0..DEPTH
OVERFLOW_G  output  1  sticky: write requested while full
UNDERFLOW_G  output  1  sticky: read requested while empty

Behaviour:
- Reset (RST_N low, asynchronous assert, takes effect without a clock edge): wr_ptr=0, rd_ptr=0, COUNT_G=0, EMPTY_G=1, FULL_G=0, FIFO_OUT_G=0, OVERFLOW_G=0, UNDERFLOW_G=0. Storage array is not reset. Reset mid-operation discards all contents; the first write after release is read back first.
- Accept rules, evaluated on register values at the clock edge: wr_acc = WR_EN & ~FULL_G; rd_acc = RD_EN & ~EMPTY_G.
- Write: on wr_acc, mem[wr_ptr] <= FIFO_IN; wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- Read: on rd_acc, FIFO_OUT_G <= mem[rd_ptr] and rd_ptr increments modulo DEPTH. Data is valid the cycle after the accepting edge, so read latency is 1 cycle. FIFO_OUT_G holds its last value when no read is accepted, including while empty.
- Count: COUNT_G += wr_acc - rd_acc, with no change when both or neither are accepted. EMPTY_G <= (next count == 0). FULL_G <= (next count == DEPTH). Flags are registered and consistent with COUNT_G in the same cycle.
- Simultaneous WR_EN & RD_EN:
  - Not empty and not full: both accepted, count unchanged.
  - Full: read accepted, write rejected. Next cycle count = DEPTH-1 and FULL_G=0.
  - Empty: write accepted, read rejected. FIFO_OUT_G is unchanged and the written word is not bypassed to the output.
- OVERFLOW_G is set on any edge with WR_EN & FULL_G. UNDERFLOW_G is set on any edge with RD_EN & EMPTY_G. Both stay set until reset. A rejected request changes no other state.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap. Full and empty are distinguished only by COUNT_G, never by pointer equality.
- X handling: WR_EN and RD_EN are treated as 0 while RST_N is low. No outputs depend combinationally on inputs.

Test Plan:
- Reset then idle: RST_N low for 3 cycles, then high, with no requests -> EMPTY_G=1, FULL_G=0, COUNT_G=0, FIFO_OUT_G=0x00, both sticky flags 0.
- Fill then drain: write 0x01..0x10 (16 writes), then 16 reads -> after the 16th write FULL_G=1 and COUNT_G=16. Reads return 0x01..0x10 in order, each one cycle after its RD_EN edge. EMPTY_G=1 after the last read.
- Boundary rejects: at full, 1 extra write of 0xAA -> OVERFLOW_G=1, COUNT_G stays 16, and 0xAA never appears in the read stream. At empty, 1 read -> UNDERFLOW_G=1, FIFO_OUT_G holds 0x10.
- Simultaneous at boundaries: at full, WR_EN=RD_EN=1 with data 0x55 -> oldest word output, COUNT_G=15, FULL_G=0, 0x55 not stored. At empty, WR_EN=RD_EN=1 with 0x66 -> COUNT_G=1, EMPTY_G=0, FIFO_OUT_G unchanged, next read returns 0x66.
- Wrap-around streaming: 40 cycles of concurrent write and read at occupancy 8, data incrementing from 0x20 -> COUNT_G constant at 8, output sequence strictly incrementing across pointer wrap, no flag toggles.
- Async reset mid-operation: assert RST_N between clock edges at COUNT_G=5 -> all outputs reach their reset values before the next edge. After release, write 0x77 and read -> 0x77 is returned.

Source files
------------

// File: rtl/fifo_golden_model.sv
// Cycle-accurate reference FIFO that produces golden data, flags, occupancy and
// sticky overflow/underflow for comparison against a FIFO under test.
module fifo_golden_model #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              SYSCLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic              RD_EN,
  input  logic [WIDTH-1:0]  FIFO_IN,
  output logic [WIDTH-1:0]  FIFO_OUT_G,
  output logic              EMPTY_G,
  output logic              FULL_G,
  output logic [ADDR_W:0]   COUNT_G,
  output logic              OVERFLOW_G,
  output logic              UNDERFLOW_G
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W:0]   count_next;

  // Handshake: WR_EN is a write valid whose ready is ~FULL_G, RD_EN is a read
  // valid whose ready is ~EMPTY_G; a transfer happens on the rising edge where
  // valid and ready are both high. A refused request only sets its sticky flag.
  always_comb begin
    wr_acc     = WR_EN & RST_N & ~FULL_G;
    rd_acc     = RD_EN & RST_N & ~EMPTY_G;
    count_next = COUNT_G;
    if (wr_acc && !rd_acc) begin
      count_next = COUNT_G + ONE_CNT;
    end else if (rd_acc && !wr_acc) begin
      count_next = COUNT_G - ONE_CNT;
    end
  end

  // Storage is deliberately not reset; pointers alone define valid contents.
  always_ff @(posedge SYSCLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= FIFO_IN;
    end
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      COUNT_G     <= '0;
      EMPTY_G     <= 1'b1;
      FULL_G      <= 1'b0;
      FIFO_OUT_G  <= '0;
      OVERFLOW_G  <= 1'b0;
      UNDERFLOW_G <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        FIFO_OUT_G <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      COUNT_G <= count_next;
      EMPTY_G <= (count_next == '0);
      FULL_G  <= (count_next == FULL_CNT);
      if (WR_EN && FULL_G) begin
        OVERFLOW_G <= 1'b1;
      end
      if (RD_EN && EMPTY_G) begin
        UNDERFLOW_G <= 1'b1;
      end
    end
  end

endmodule
